// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, flag bit positions and
// the output-register FSM state type.
package alu_pkg;

    // Opcodes carried on sel
    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_DEC = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_INC = 3'b111;

    // Bit positions inside the 4-bit flags word {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Output register occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } pipe_state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: sel, a, b -> result and {N,Z,C,V}.
// Flag logic exists only when ALU_PIPE_FLAGS_EN is defined; otherwise flags
// are tied to zero.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    // All arithmetic ops share one adder: a + opb + cin.
    // sub uses ~b+1, dec adds all-ones, inc adds zero with carry-in.
    logic [WIDTH-1:0] opb;
    logic             cin;
    logic [WIDTH:0]   sum;

    // Select the second adder operand and carry-in from the opcode
    always_comb begin
        opb = '0;
        cin = 1'b0;
        case (sel)
            OP_ADD: begin opb = b;        cin = 1'b0; end
            OP_SUB: begin opb = ~b;       cin = 1'b1; end
            OP_DEC: begin opb = '1;       cin = 1'b0; end
            OP_INC: begin opb = '0;       cin = 1'b1; end
            default: begin opb = '0;      cin = 1'b0; end
        endcase
    end

    assign sum = {1'b0, a} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};

    // Pick the logic result or the adder result
    always_comb begin
        result = '0;
        case (sel)
            OP_NOT:  result = ~a;
            OP_AND:  result = a & b;
            OP_XOR:  result = a ^ b;
            OP_OR:   result = a | b;
            default: result = sum[WIDTH-1:0];
        endcase
    end

`ifdef ALU_PIPE_FLAGS_EN
    logic is_arith;
    logic is_borrow_op;

    assign is_arith     = sel[2];
    assign is_borrow_op = (sel == OP_SUB) || (sel == OP_DEC);

    // N/Z from the result; C/V from the shared adder, zero for logic ops.
    // Subtract-style ops report borrow, which is the inverted adder carry.
    always_comb begin
        flags         = 4'b0000;
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_Z] = (result == '0);
        if (is_arith) begin
            flags[FLAG_C] = is_borrow_op ? ~sum[WIDTH] : sum[WIDTH];
            flags[FLAG_V] = (a[WIDTH-1] == opb[WIDTH-1]) &&
                            (result[WIDTH-1] != a[WIDTH-1]);
        end
    end
`else
    logic unused_carry;
    assign unused_carry = sum[WIDTH];
    assign flags        = 4'b0000;
`endif

endmodule

// File: rtl/alu_pipe.sv
// Single-stage pipelined ALU with valid/ready handshake on both sides.
// Optional flag generation is enabled with the ALU_PIPE_FLAGS_EN macro.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready = !out_valid || out_ready, so a held result that is being
// delivered can be replaced by a new one in the same cycle (no bubble).
// While out_valid && !out_ready, out/flags stay frozen and inputs are ignored.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output pipe_state_t      state
);

    logic [WIDTH-1:0] core_result;
    logic [3:0]       core_flags;
    logic             accept;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .sel    (sel),
        .a      (a),
        .b      (b),
        .result (core_result),
        .flags  (core_flags)
    );

    assign in_ready  = (state == EMPTY) || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == FULL);

    // Occupancy FSM and result registers; reset discards any held result
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            out   <= '0;
            flags <= 4'b0000;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state <= FULL;
                        out   <= core_result;
                        flags <= core_flags;
                    end
                end
                FULL: begin
                    if (accept) begin
                        out   <= core_result;
                        flags <= core_flags;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=32). Expected results come from a
// behavioural model pushed into a queue on accept and popped on delivery.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [3:0]       flags;
    pipe_state_t      state;

    int checks = 0;
    int errors = 0;
    logic [WIDTH+3:0] exp_q[$];

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags),
        .state     (state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: returns {flags, result}
    function automatic logic [WIDTH+3:0] model(input logic [2:0] s,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        logic [3:0]       f;
        c = 1'b0;
        v = 1'b0;
        case (s)
            3'b000: r = ~x;
            3'b001: r = x & y;
            3'b010: r = x ^ y;
            3'b011: r = x | y;
            3'b100: begin
                r = x - 1;
                c = (x == 0);
                v = (x == {1'b1, {(WIDTH-1){1'b0}}});
            end
            3'b101: begin
                r = x + y;
                c = (r < x);
                v = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
            end
            3'b110: begin
                r = x - y;
                c = (x < y);
                v = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
            end
            default: begin
                r = x + 1;
                c = (x == {WIDTH{1'b1}});
                v = (x == {1'b0, {(WIDTH-1){1'b1}}});
            end
        endcase
        f = {r[WIDTH-1], (r == 0), c, v};
`ifndef ALU_PIPE_FLAGS_EN
        f = 4'b0000;
`endif
        return {f, r};
    endfunction

    // One clock cycle: inputs are already driven; sample mid-cycle, update
    // the scoreboard, then move to 1 time unit after the rising edge.
    task automatic tick();
        logic             acc;
        logic [WIDTH+3:0] e;
        logic [WIDTH+3:0] got;
        e = '0;
        @(negedge clk);
        acc = in_valid && in_ready && !rst;
        if (rst) begin
            exp_q.delete();
        end else if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL deliver_unexpected: got out=%h flags=%b, required no delivery", out, flags);
            end else begin
                got = {flags, out};
                e   = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL deliver_value: got %h, required %h", got, e);
                end
            end
        end
        if (acc) begin
            e = model(sel, a, b);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (acc) begin
            checks++;
            if (out_valid !== 1'b1 || {flags, out} !== e) begin
                errors++;
                $display("FAIL latency: got valid=%b %h, required valid=1 %h", out_valid, {flags, out}, e);
            end
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] s,
                         input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        in_valid = v;
        sel      = s;
        a        = x;
        b        = y;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 3'b000, '0, '0);
        out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || out !== '0 || flags !== 4'b0000 || state !== EMPTY) begin
            errors++;
            $display("FAIL reset_state: got valid=%b out=%h flags=%b st=%0d, required 0/0/0/EMPTY",
                     out_valid, out, flags, state);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_all_ops();
        logic [WIDTH-1:0] tbl [8];
        tbl = '{32'hEDCBA987, 32'h02244220, 32'h95511559, 32'h97755779,
                32'h12345677, 32'h99999999, 32'h8ACF1357, 32'h12345679};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 32'h12345678, 32'h87654321);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL ops_in_ready[%0d]: got %b, required 1", i, in_ready);
            end
            tick();
            checks++;
            if (out !== tbl[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL ops_out[%0d]: got %h valid=%b, required %h valid=1", i, out, out_valid, tbl[i]);
            end
        end
        drive(1'b0, 3'b000, '0, '0);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ops_drain: got valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_boundary();
        logic [2:0]       s [3];
        logic [WIDTH-1:0] x [3];
        logic [WIDTH-1:0] y [3];
        logic [WIDTH-1:0] ro [3];
        logic [3:0]       rf [3];
        s  = '{3'b111, 3'b100, 3'b101};
        x  = '{32'hFFFFFFFF, 32'h00000000, 32'h7FFFFFFF};
        y  = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000001};
        ro = '{32'h00000000, 32'hFFFFFFFF, 32'h80000000};
`ifdef ALU_PIPE_FLAGS_EN
        rf = '{4'b0110, 4'b1010, 4'b1001};
`else
        rf = '{4'b0000, 4'b0000, 4'b0000};
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, s[i], x[i], y[i]);
            tick();
            checks++;
            if (out !== ro[i] || flags !== rf[i]) begin
                errors++;
                $display("FAIL boundary[%0d]: got out=%h flags=%b, required out=%h flags=%b",
                         i, out, flags, ro[i], rf[i]);
            end
        end
        drive(1'b0, 3'b000, '0, '0);
        tick();
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] held_out;
        logic [3:0]       held_flags;
        out_ready = 1'b0;
        drive(1'b1, 3'b101, 32'h00001000, 32'h00000234);
        tick();
        held_out   = out;
        held_flags = flags;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom);
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_in_ready[%0d]: got %b, required 0", i, in_ready);
            end
            tick();
            checks++;
            if (out !== held_out || flags !== held_flags || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_stable[%0d]: got %h/%b valid=%b, required %h/%b valid=1",
                         i, out, flags, out_valid, held_out, held_flags);
            end
        end
        out_ready = 1'b1;
        drive(1'b1, 3'b110, 32'h00000005, 32'h00000007);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b, required 1", in_ready);
        end
        tick();
        checks++;
        if (out !== 32'hFFFFFFFE) begin
            errors++;
            $display("FAIL bp_next_result: got %h, required fffffffe", out);
        end
        drive(1'b0, 3'b000, '0, '0);
        tick();
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        drive(1'b1, 3'b011, 32'h0F0F0000, 32'h0000F0F0);
        tick();
        rst = 1'b1;
        drive(1'b1, 3'b111, 32'h00000010, '0);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstfull_in_ready: got %b, required 0", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out !== '0 || flags !== 4'b0000) begin
            errors++;
            $display("FAIL rstfull_clear: got valid=%b out=%h flags=%b, required 0/0/0", out_valid, out, flags);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 3'b111, 32'h00000010, '0);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out !== 32'h00000011) begin
            errors++;
            $display("FAIL rstfull_first_op: got valid=%b out=%h, required 1/00000011", out_valid, out);
        end
        drive(1'b0, 3'b000, '0, '0);
        tick();
    endtask

    task automatic test_idle();
        logic [WIDTH-1:0] last;
        last = out;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
            tick();
        end
        checks++;
        if (out !== last || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got %h valid=%b, required %h valid=0", out, out_valid, last);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
            if ($urandom_range(0, 9) == 0) a = 32'hFFFFFFFF;
            if ($urandom_range(0, 9) == 0) a = 32'h80000000;
            out_ready = 1'($urandom_range(0, 3) != 0);
            tick();
        end
        drive(1'b0, 3'b000, '0, '0);
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        sel = 3'b000;
        a = '0;
        b = '0;
        out_ready = 1'b0;
        test_reset();
        test_all_ops();
        test_boundary();
        test_backpressure();
        test_reset_full();
        test_idle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; legal values 8..64.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  operands and sel valid this cycle.
REQ-005 Port: in_ready  output  1  block can accept an operation this cycle.
REQ-006 Port: sel  input  3  opcode: 000 ~a, 001 a&b, 010 a^b, 011 a|b, 100 a-1, 101 a+b, 110 a-b, 111 a+1.
REQ-007 Port: a  input  WIDTH  operand A.
REQ-008 Port: b  input  WIDTH  operand B; ignored for 000, 100, 111.
REQ-009 Port: out_valid  output  1  result register holds an undelivered result.
REQ-010 Port: out_ready  input  1  consumer accepts result this cycle.
REQ-011 Port: out  output  WIDTH  registered result.
REQ-012 Port: flags  output  4  registered {N,Z,C,V}, bit3=N, bit0=V.

Function
REQ-013 Handshake: input accepted on cycle where in_valid && in_ready; output delivered where out_valid && out_ready.
REQ-014 in_ready SHALL equal !out_valid || out_ready (combinational, single-entry skid-free buffer).
REQ-015 Latency: accepted op SHALL appear on out/flags with out_valid=1 on the next rising edge (1 cycle).
REQ-016 FSM states: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-017 EMPTY -> FULL on accept; FULL -> EMPTY on deliver without accept; FULL -> FULL on simultaneous deliver and accept (new result replaces old, no bubble); FULL holds on !out_ready.
REQ-018 While FULL and !out_ready, out and flags SHALL hold stable; a, b, sel SHALL be ignored.
REQ-019 Arithmetic modulo 2^WIDTH; wrap-around silent: all-ones + 1 = 0, 0 - 1 = all-ones.
REQ-020 N = out[WIDTH-1]; Z = (out == 0), for all opcodes.
REQ-021 C: add/inc = carry out of MSB; sub/dec = 1 on borrow (unsigned a < subtrahend); logic ops C=0.
REQ-022 V: signed overflow for 100,101,110,111 (two's complement rule); logic ops V=0.
REQ-023 in_valid=0 SHALL never change out/flags.

Reset
REQ-024 On rst=1 at clock edge: out_valid=0, out=0, flags=0, FSM=EMPTY.
REQ-025 rst SHALL take priority over any simultaneous accept or deliver; a held result is discarded.
REQ-026 in_ready during rst cycle follows REQ-014 from current state; input accepted in that cycle is dropped.

Configuration
REQ-027 Macro ALU_PIPE_FLAGS_EN: when defined, flags computed per REQ-020..022.
REQ-028 When undefined, flags SHALL be tied to 4'b0000, flag logic absent; out/handshake unchanged.

Structure
REQ-029 Shared package alu_pkg SHALL hold opcode constants (OP_NOT..OP_INC), flag bit indices, and the FSM state type.
REQ-030 Combinational datapath SHALL be a sub-module alu_core (sel, a, b -> result, flags), parametrised by WIDTH; alu_pipe holds handshake, FSM and registers.

Verification
REQ-031 WIDTH=32, a=12345678h, b=87654321h, out_ready=1, sel 000..111 back-to-back -> out EDCBA987h, 02244220h, 95511559h, 97755779h, 12345677h, 99999999h, 8ACF1357h, 12345679h, one per cycle, in_ready held 1.
REQ-032 sel=111, a=FFFFFFFFh -> out=0, flags Z=1, C=1, N=0, V=0; sel=100, a=0 -> out=FFFFFFFFh, N=1, C=1.
REQ-033 sel=101, a=7FFFFFFFh, b=1 -> out=80000000h, N=1, V=1, C=0.
REQ-034 Backpressure: accept op, hold out_ready=0 for 3 cycles while driving new operands -> in_ready=0, out stable; out_ready=1 with in_valid=1 -> deliver and accept same cycle, next result one cycle later.
REQ-035 Assert rst while FULL and out_ready=0 -> next cycle out_valid=0, out=0, flags=0; first post-reset op has 1-cycle latency.
REQ-036 Build without ALU_PIPE_FLAGS_EN, rerun REQ-032 -> out identical, flags=0.
